shift_arbiter: RTL

SHIFT_ARBITER -- requirements
Module: shift_arbiter

---
 rtl/shift_arbiter.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/shift_arbiter.sv
// shift_arbiter: two-requester front end that time-shares one right_shifter.
// Left shifts reuse the right shifter by bit-reversing the operand on the way
// in and the result on the way out. Each operation takes IDLE -> EXEC -> HOLD,
// and arbitration between requesters is round-robin.
// Optional feature: define SHIFT_ARBITER_ROTATE_EN to add per-requester rotate
// ports (req0_rot / req1_rot) that wrap the vacated bits back in.

// Logarithmic logical right shifter: one conditional power-of-two stage per
// bit of the shift amount, vacated bits filled with 0.
module right_shifter #(
  parameter int width = 8,
  localparam int level = $clog2(width)
) (
  input  logic [width-1:0] din,
  input  logic [level-1:0] shamt,
  output logic [width-1:0] dout
);

  // Cascade of stages; stage i shifts by 2**i when shamt[i] is set
  always_comb begin
    logic [width-1:0] v;
    v = din;
    for (int i = 0; i < level; i++) begin
      if (shamt[i]) v = v >> (2 ** i);
    end
    dout = v;
  end

endmodule

module shift_arbiter #(
  parameter int width = 8,
  localparam int level = $clog2(width)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [width-1:0] req0_a,
  input  logic [level-1:0] req0_b,
  input  logic             req0_dir,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [width-1:0] req1_a,
  input  logic [level-1:0] req1_b,
  input  logic             req1_dir,
`ifdef SHIFT_ARBITER_ROTATE_EN
  input  logic             req0_rot,
  input  logic             req1_rot,
`endif
  output logic             res_valid,
  input  logic             res_ready,
  output logic [width-1:0] res_data,
  output logic             res_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             rr_q, rr_d;
  logic [width-1:0] a_q, a_d;
  logic [level-1:0] b_q, b_d;
  logic             dir_q, dir_d;
  logic             id_q, id_d;
`ifdef SHIFT_ARBITER_ROTATE_EN
  logic             rot_q, rot_d;
`endif
  logic [width-1:0] res_data_q, res_data_d;
  logic             res_valid_q, res_valid_d;
  logic             res_id_q, res_id_d;

  logic             any_req;
  logic             gnt_id;
  logic             grant;
  logic             exec_en;
  logic             consume;
  logic [width-1:0] sh_in;
  logic [width-1:0] sh_out;
  logic [width-1:0] shift_res;

  // Mirror a word end-for-end so a right shift acts as a left shift
  function automatic logic [width-1:0] bit_rev(input logic [width-1:0] v);
    logic [width-1:0] r;
    for (int i = 0; i < width; i++) begin
      r[i] = v[width-1-i];
    end
    return r;
  endfunction

  // Arbitration: a lone requester wins; on contention the rr pointer decides
  always_comb begin
    any_req = req0_valid | req1_valid;
    gnt_id  = (req0_valid && req1_valid) ? rr_q : req1_valid;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = EXEC;
      EXEC:    state_d = HOLD;
      HOLD:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: ready only in the IDLE grant cycle and never under reset
  always_comb begin
    grant      = (state_q == IDLE) && any_req && rst_n;
    req0_ready = grant && !gnt_id;
    req1_ready = grant && gnt_id;
    exec_en    = (state_q == EXEC);
    consume    = (state_q == HOLD) && res_valid_q && res_ready;
  end

  // Operand capture and round-robin update on the grant edge
  always_comb begin
    rr_d  = rr_q;
    a_d   = a_q;
    b_d   = b_q;
    dir_d = dir_q;
    id_d  = id_q;
`ifdef SHIFT_ARBITER_ROTATE_EN
    rot_d = rot_q;
`endif
    if (grant) begin
      rr_d  = ~gnt_id;
      id_d  = gnt_id;
      a_d   = gnt_id ? req1_a   : req0_a;
      b_d   = gnt_id ? req1_b   : req0_b;
      dir_d = gnt_id ? req1_dir : req0_dir;
`ifdef SHIFT_ARBITER_ROTATE_EN
      rot_d = gnt_id ? req1_rot : req0_rot;
`endif
    end
  end

  // Operand pre-conditioning: reverse bits for a left shift
  always_comb begin
    sh_in = dir_q ? bit_rev(a_q) : a_q;
  end

  right_shifter #(.width(width)) u_right_shifter (
    .din   (sh_in),
    .shamt (b_q),
    .dout  (sh_out)
  );

  // Result post-conditioning: undo the reversal, optionally wrap shifted-out bits
  always_comb begin
`ifdef SHIFT_ARBITER_ROTATE_EN
    int rot_amt;
    // Shifting by width - b in the opposite direction recovers the bits that
    // fell off; with b = 0 the amount equals width and contributes nothing.
    rot_amt   = width - int'(b_q);
`endif
    shift_res = dir_q ? bit_rev(sh_out) : sh_out;
`ifdef SHIFT_ARBITER_ROTATE_EN
    if (rot_q) begin
      shift_res = shift_res | (dir_q ? (a_q >> rot_amt) : (a_q << rot_amt));
    end
`endif
  end

  // Result register: load in EXEC, hold through HOLD, drop valid on handshake
  always_comb begin
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    res_valid_d = res_valid_q;
    if (exec_en) begin
      res_data_d  = shift_res;
      res_id_d    = id_q;
      res_valid_d = 1'b1;
    end else if (consume) begin
      res_valid_d = 1'b0;
    end
  end

  // Control and datapath registers; reset discards any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      dir_q       <= 1'b0;
      id_q        <= 1'b0;
`ifdef SHIFT_ARBITER_ROTATE_EN
      rot_q       <= 1'b0;
`endif
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      dir_q       <= dir_d;
      id_q        <= id_d;
`ifdef SHIFT_ARBITER_ROTATE_EN
      rot_q       <= rot_d;
`endif
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;

endmodule
